// File: rtl/wall32_seq_pkg.sv
// Shared types and constants for the 32x32 sequential multiplier built on one 16x16 multiplier.
// Optional build macro: WALL32_ZERO_SKIP_EN (skip partial products whose operand halves are zero).
package wall32_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit 1 selects the upper half of a, bit 0 the upper half of b.
    typedef enum logic [1:0] {
        STEP_S0 = 2'd0,
        STEP_S1 = 2'd1,
        STEP_S2 = 2'd2,
        STEP_S3 = 2'd3
    } step_e;

    localparam int unsigned SHIFT_S0 = 0;
    localparam int unsigned SHIFT_S1 = 16;
    localparam int unsigned SHIFT_S2 = 16;
    localparam int unsigned SHIFT_S3 = 32;

    function automatic logic [63:0] shift_pp(input logic [31:0] pp, input step_e step);
        logic [63:0] wide;
        wide = {32'd0, pp};
        case (step)
            STEP_S0: shift_pp = wide << SHIFT_S0;
            STEP_S1: shift_pp = wide << SHIFT_S1;
            STEP_S2: shift_pp = wide << SHIFT_S2;
            default: shift_pp = wide << SHIFT_S3;
        endcase
    endfunction

`ifdef WALL32_ZERO_SKIP_EN
    function automatic logic [3:0] step_mask(input logic [31:0] a, input logic [31:0] b);
        step_mask[0] = (a[15:0]  != 16'd0) && (b[15:0]  != 16'd0);
        step_mask[1] = (a[15:0]  != 16'd0) && (b[31:16] != 16'd0);
        step_mask[2] = (a[31:16] != 16'd0) && (b[15:0]  != 16'd0);
        step_mask[3] = (a[31:16] != 16'd0) && (b[31:16] != 16'd0);
    endfunction
`endif

endpackage

// File: rtl/wall32_seq_mul_wall16bit.sv
// Shared unsigned 16x16 -> 32 multiplier used once per step by wall32_seq_mul.
module wall16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] p_o
);

    assign p_o = 32'(a_i) * 32'(b_i);

endmodule

// File: rtl/wall32_seq_mul.sv
// 32x32 -> 64 unsigned multiplier: one 16x16 partial product accumulated per clock.
// Build macro WALL32_ZERO_SKIP_EN enables skipping of steps with a zero operand half.
module wall32_seq_mul
    import wall32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] p,
    output logic        busy
);

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    logic [31:0] a_q, b_q;
    logic [63:0] acc_q, acc_d;
    logic [15:0] a_half, b_half;
    logic [31:0] pp;
    logic        accept;
    logic        last_step;
    logic        do_add;
    step_e       first_step;
    step_e       next_step;

    assign accept = in_valid && (state_q == IDLE);

    assign a_half = step_q[1] ? a_q[31:16] : a_q[15:0];
    assign b_half = step_q[0] ? b_q[31:16] : b_q[15:0];

    wall16bit u_wall16bit (
        .a_i (a_half),
        .b_i (b_half),
        .p_o (pp)
    );

`ifdef WALL32_ZERO_SKIP_EN
    logic [3:0] mask_q, mask_d;

    // An all-zero mask parks on S0 with do_add low, giving the one-cycle pass to DONE.
    always_comb begin
        mask_d     = step_mask(a, b);
        first_step = STEP_S0;
        next_step  = step_q;
        last_step  = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (mask_d[i]) first_step = step_e'(2'(i));
            if (mask_q[i] && (i > int'(step_q))) begin
                next_step = step_e'(2'(i));
                last_step = 1'b0;
            end
        end
        do_add = mask_q[step_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      mask_q <= 4'd0;
        else if (accept) mask_q <= mask_d;
    end
`else
    always_comb begin
        first_step = STEP_S0;
        next_step  = step_e'(step_q + 2'd1);
        last_step  = (step_q == STEP_S3);
        do_add     = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = MUL;
            MUL:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        step_d = step_q;
        acc_d  = acc_q;
        if (accept) begin
            step_d = first_step;
            acc_d  = 64'd0;
        end else if (state_q == MUL) begin
            if (do_add)     acc_d  = acc_q + shift_pp(pp, step_q);
            if (!last_step) step_d = next_step;
        end
    end

    // NOTE: the datapath is cleared by the synchronous reset so p reads 0 after reset, not X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q <= STEP_S0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            acc_q  <= 64'd0;
        end else begin
            step_q <= step_d;
            acc_q  <= acc_d;
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    assign p = acc_q;

endmodule

// File: tb/tb_wall32_seq_mul.sv
// Randomized and directed bench for wall32_seq_mul against a plain a*b reference with latency rule.
module tb_wall32_seq_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] p;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    wall32_seq_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_product(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic int ref_latency(input logic [31:0] x, input logic [31:0] y);
`ifdef WALL32_ZERO_SKIP_EN
        int n;
        n = 0;
        if (x[15:0]  != 0 && y[15:0]  != 0) n++;
        if (x[15:0]  != 0 && y[31:16] != 0) n++;
        if (x[31:16] != 0 && y[15:0]  != 0) n++;
        if (x[31:16] != 0 && y[31:16] != 0) n++;
        return (n == 0) ? 1 : n;
`else
        return 4;
`endif
    endfunction

    // One full transaction: accept, measure latency, optionally stall the consumer, then drain.
    task automatic test_single_op(input logic [31:0] op_a, input logic [31:0] op_b,
                                  input int hold, input string name);
        logic [63:0] exp_p;
        int          exp_lat;
        int          cyc;
        exp_p   = ref_product(op_a, op_b);
        exp_lat = ref_latency(op_a, op_b);

        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: got %b want 1", name, in_ready);
        end
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s mul_flags: busy=%b in_ready=%b out_valid=%b want 1/0/0",
                     name, busy, in_ready, out_valid);
        end

        cyc = 1;
        @(posedge clk);
        #1;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_cmp++;
        if (cyc != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        n_cmp++;
        if (p !== exp_p) begin
            n_fail++;
            $display("FAIL %s product: got %h want %h", name, p, exp_p);
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || p !== exp_p || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s hold%0d: out_valid=%b p=%h in_ready=%b busy=%b want 1/%h/0/1",
                         name, i, out_valid, p, in_ready, busy, exp_p);
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = $urandom;
        b = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (p !== 64'd0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: p=%h out_valid=%b busy=%b in_ready=%b want 0/0/0/1",
                     p, out_valid, busy, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        test_single_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max");
        test_single_op(32'h0002_0003, 32'h0004_0005, 0, "small_halves");
        test_single_op(32'h0001_0000, 32'h0001_0000, 0, "s3_only");
        test_single_op(32'h0000_0000, 32'h0000_1234, 0, "zero_a");
    endtask

    task automatic test_hold();
        test_single_op(32'hDEAD_BEEF, 32'h1234_5678, 10, "hold");
    endtask

    task automatic test_mid_reset();
        logic seen;
        @(negedge clk);
        a = $urandom | 32'h0001_0001;
        b = $urandom | 32'h0001_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (p !== 64'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: p=%h out_valid=%b in_ready=%b busy=%b want 0/0/1/0",
                     p, out_valid, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_no_pulse: out_valid seen=%b want 0", seen);
        end
        test_single_op(32'd3, 32'd5, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 2) == 0) ra[15:0]  = 16'd0;
            if ($urandom_range(0, 2) == 0) ra[31:16] = 16'd0;
            if ($urandom_range(0, 2) == 0) rb[15:0]  = 16'd0;
            if ($urandom_range(0, 2) == 0) rb[31:16] = 16'd0;
            test_single_op(ra, rb, $urandom_range(0, 2), $sformatf("rand%0d", k));
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] results[$];
        int          acc_cyc[$];
        int          out_cyc[$];
        logic        will_accept;
        int          cyc;
        out_ready = 1'b1;
        a = 32'd3;
        b = 32'd5;
        in_valid = 1'b1;
        cyc = 0;
        while (results.size() < 2 && cyc < 40) begin
            @(negedge clk);
            will_accept = in_ready && in_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (will_accept) begin
                acc_cyc.push_back(cyc);
                if (acc_cyc.size() == 1) begin
                    a = 32'h0002_0003;
                    b = 32'h0004_0005;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                results.push_back(p);
                out_cyc.push_back(cyc);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (results.size() != 2 || acc_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: results=%0d accepts=%0d want 2/2", results.size(), acc_cyc.size());
        end else begin
            n_cmp++;
            if (results[0] !== 64'd15 || results[1] !== 64'h0000_0008_0016_000F) begin
                n_fail++;
                $display("FAIL b2b_results: got %h,%h want %h,%h",
                         results[0], results[1], 64'd15, 64'h0000_0008_0016_000F);
            end
            n_cmp++;
            if (out_cyc[0] - acc_cyc[0] != ref_latency(32'd3, 32'd5) ||
                out_cyc[1] - acc_cyc[1] != ref_latency(32'h0002_0003, 32'h0004_0005)) begin
                n_fail++;
                $display("FAIL b2b_latency: got %0d,%0d want %0d,%0d",
                         out_cyc[0] - acc_cyc[0], out_cyc[1] - acc_cyc[1],
                         ref_latency(32'd3, 32'd5), ref_latency(32'h0002_0003, 32'h0004_0005));
            end
            n_cmp++;
            if (acc_cyc[1] - out_cyc[0] != 2) begin
                n_fail++;
                $display("FAIL b2b_gap: got %0d want 2", acc_cyc[1] - out_cyc[0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wall32_seq_mul.md
WALL32_SEQ_MUL -- requirements
Module: wall32_seq_mul

Interface
REQ-001 SHALL have no parameters; all widths fixed (32-bit operands, 64-bit product).
REQ-002 SHALL use a single clock and a synchronous, active-low reset.
REQ-003 SHALL provide the following ports, one per line:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands
- a  input  32  unsigned multiplicand
- b  input  32  unsigned multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- p  output  64  unsigned product
- busy  output  1  high in any state other than IDLE

Function
REQ-004 SHALL compute p = a*b (unsigned, exact 64-bit) using one shared 16x16 multiplier, one partial product per clock.
REQ-005 SHALL sequence steps in a fixed order:
- S0: a[15:0]*b[15:0], shift 0
- S1: a[15:0]*b[31:16], shift 16
- S2: a[31:16]*b[15:0], shift 16
- S3: a[31:16]*b[31:16], shift 32
REQ-006 SHALL accumulate each step into a 64-bit accumulator; the carry out of bit 63 is impossible and SHALL NOT be checked.
REQ-007 SHALL implement the FSM states IDLE, MUL and DONE.
- IDLE -> MUL on in_valid && in_ready.
- MUL -> DONE after the last enabled step.
- DONE -> IDLE on out_valid && out_ready.
REQ-008 in_ready SHALL equal (state==IDLE); an accepted transfer latches a and b and clears the accumulator on the accepting edge T.
REQ-009 With all steps enabled, steps SHALL update the accumulator on edges T+1..T+4, and out_valid SHALL be high from edge T+4 until the handshake edge.
REQ-010 While out_valid is high, p SHALL hold stable; in_valid SHALL be ignored; there is no accept in the same cycle as the output handshake.
REQ-011 p SHALL present the accumulator register; its value outside DONE is unspecified except after reset.
REQ-012 Changes on a or b after the accept edge SHALL NOT affect the result.

Reset
REQ-013 While rst_n=0 at a clock edge, the block SHALL load:
- state=IDLE, accumulator/p=0, out_valid=0, busy=0
- step index and latched operands = 0
REQ-014 in_ready SHALL be 1 in the first cycle after reset.
REQ-015 Reset asserted mid-MUL or in DONE SHALL abort the operation with no out_valid pulse.

Configuration
REQ-016 SHALL support the macro WALL32_ZERO_SKIP_EN.
REQ-017 With WALL32_ZERO_SKIP_EN defined:
- On accept, the block SHALL compute a 4-bit step mask; a step is disabled when either of its 16-bit operand halves is zero.
- MUL SHALL visit only enabled steps, in S0..S3 order, one per clock.
- If the mask is all-zero, the accumulator SHALL remain 0 and out_valid SHALL rise on edge T+1.
- Latency SHALL be max(1, popcount(mask)) cycles.
REQ-018 Without WALL32_ZERO_SKIP_EN, all four steps SHALL always execute (latency 4) and no mask logic SHALL exist.

Structure
REQ-019 Package wall32_seq_pkg SHALL hold:
- the FSM state typedef (IDLE/MUL/DONE)
- the 2-bit step-index encoding
- the per-step shift constants (0, 16, 16, 32)
REQ-020 SHALL instantiate exactly one wall16bit as the shared multiplier sub-module; operand half selection is a mux driven by the step index.

Verification
REQ-021 a=0xFFFFFFFF, b=0xFFFFFFFF -> p=0xFFFFFFFE00000001, out_valid at T+4 (both configurations).
REQ-022 a=0x00020003, b=0x00040005 -> p=0x000000080016000F, latency 4 (both configurations).
REQ-023 a=0x00010000, b=0x00010000 -> p=0x0000000100000000; latency 4 without the macro, 1 with it (S3 only); a=0, b=0x1234 -> p=0, latency 1 with the macro.
REQ-024 Hold out_ready=0 for 10 cycles after out_valid, toggling in_valid and a/b:
- p stays stable, in_ready=0, busy=1
- release -> IDLE next cycle
REQ-025 Assert rst_n=0 for one edge during step S2 -> out_valid never pulses, p=0, in_ready=1 the next cycle; a new op a=3, b=5 -> p=15.
REQ-026 Back-to-back ops (a=3, b=5, then a=0x00020003, b=0x00040005) with out_ready=1 -> results 15 and 0x000000080016000F in order, one idle cycle between them.
